free_list_bank: RTL and testbench

//  One bank of the physical-register free list: circular FIFO of upper_PR_t values for PRs whose

---
 rtl/free_list_bank_pkg.sv | 19 +
 rtl/free_list_bank_if.sv | 26 ++
 rtl/free_list_bank.sv | 66 ++++++
 tb/tb_free_list_bank.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/free_list_bank_pkg.sv
// Shared types and sizing for the physical-register free list.
// A full PR number is {upper_PR_t, bank bits}.
package free_list_bank_pkg;

  localparam int PR_COUNT                  = 128;
  localparam int AR6_COUNT                 = 64;
  localparam int FREE_LIST_BANK_COUNT      = 4;
  localparam int LOG_PRF_BANK_COUNT        = $clog2(FREE_LIST_BANK_COUNT);
  localparam int FREE_LIST_LENGTH_PER_BANK = PR_COUNT / FREE_LIST_BANK_COUNT;
  localparam int LOG_FREE_LIST_LENGTH_PER_BANK = $clog2(FREE_LIST_LENGTH_PER_BANK);
  localparam int FREE_LIST_LOWER_THRESHOLD = 8;
  localparam int FREE_LIST_UPPER_THRESHOLD = 24;

  typedef logic [$clog2(PR_COUNT)-LOG_PRF_BANK_COUNT-1:0] upper_PR_t;

  // One extra bit above the index so that full and empty can be told apart.
  typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK:0] free_list_ptr_t;

endpackage

// File: rtl/free_list_bank_if.sv
// Dealloc (enqueue) and alloc (dequeue) handshakes plus occupancy reporting of one bank.
// The slave modport is the bank itself; the master modport is the ROB/rename side.
interface free_list_bank_if;
  import free_list_bank_pkg::*;

  logic           dealloc_valid;
  upper_PR_t      dealloc_PR_upper;
  logic           dealloc_ready;
  logic           alloc_valid;
  upper_PR_t      alloc_PR_upper;
  logic           alloc_ready;
  free_list_ptr_t count;
  logic           below_lower;
  logic           above_upper;

  modport master (
    output dealloc_valid, dealloc_PR_upper, alloc_ready,
    input  dealloc_ready, alloc_valid, alloc_PR_upper, count, below_lower, above_upper
  );

  modport slave (
    input  dealloc_valid, dealloc_PR_upper, alloc_ready,
    output dealloc_ready, alloc_valid, alloc_PR_upper, count, below_lower, above_upper
  );

endinterface

// File: rtl/free_list_bank.sv
// One free-list bank: circular FIFO of upper PR indices with show-ahead head,
// occupancy count and balancing threshold flags, all derived from registered state.
module free_list_bank
  import free_list_bank_pkg::*;
#(
  parameter int BANK_IDX        = 0,
  parameter int LENGTH          = FREE_LIST_LENGTH_PER_BANK,
  parameter int INIT_FREE_START = AR6_COUNT / FREE_LIST_BANK_COUNT,
  parameter int LOWER_THRESHOLD = FREE_LIST_LOWER_THRESHOLD,
  parameter int UPPER_THRESHOLD = FREE_LIST_UPPER_THRESHOLD,
  parameter bit CHECK_OVERFLOW  = 1'b1
) (
  input logic             CLK,
  input logic             nRST,
  free_list_bank_if.slave bank
);

  localparam int IDX_W = LOG_FREE_LIST_LENGTH_PER_BANK;

  upper_PR_t      entries [LENGTH];
  free_list_ptr_t head_ptr;
  free_list_ptr_t tail_ptr;
  free_list_ptr_t count;
  logic           empty;
  logic           full;
  logic           enq_fire;
  logic           deq_fire;

  assign count    = tail_ptr - head_ptr;
  assign empty    = (count == '0);
  assign full     = (count == free_list_ptr_t'(LENGTH));
  assign enq_fire = bank.dealloc_valid && !full;
  assign deq_fire = bank.alloc_ready && !empty;

  assign bank.dealloc_ready  = !full;
  assign bank.alloc_valid    = !empty;
  assign bank.alloc_PR_upper = entries[head_ptr[IDX_W-1:0]];
  assign bank.count          = count;
  assign bank.below_lower    = (count < free_list_ptr_t'(LOWER_THRESHOLD));
  assign bank.above_upper    = (count > free_list_ptr_t'(UPPER_THRESHOLD));

  // Reset preloads the PRs not claimed by the architectural mappings.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < LENGTH; i++) begin
        entries[i] <= (i < LENGTH - INIT_FREE_START) ? upper_PR_t'(INIT_FREE_START + i) : '0;
      end
      head_ptr <= '0;
      tail_ptr <= free_list_ptr_t'(LENGTH - INIT_FREE_START);
    end else begin
      if (enq_fire) begin
        entries[tail_ptr[IDX_W-1:0]] <= bank.dealloc_PR_upper;
        tail_ptr                     <= tail_ptr + free_list_ptr_t'(1);
      end
      if (deq_fire) begin
        head_ptr <= head_ptr + free_list_ptr_t'(1);
      end
    end
  end

  // PRs are conserved system-wide, so a dealloc into a full bank means an upstream bug.
  overflow_chk: assert property (@(posedge CLK) disable iff (!nRST || !CHECK_OVERFLOW)
                                 !(bank.dealloc_valid && full))
    else $error("free_list_bank %0d: dealloc while full", BANK_IDX);

endmodule

// File: tb/tb_free_list_bank.sv
// Directed bench for free_list_bank: reset contents, drain, refill, full/empty
// handling, wraparound with simultaneous traffic, thresholds and mid-traffic reset.
module tb_free_list_bank;
  import free_list_bank_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  free_list_bank_if bus ();

  free_list_bank #(.CHECK_OVERFLOW(1'b0)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bank (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks sample at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dealloc_valid    = 1'b0;
    bus.dealloc_PR_upper = '0;
    bus.alloc_ready      = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    idle();
    step();
    nrst = 1'b1;
  endtask

  task automatic dealloc(input int v);
    bus.dealloc_valid    = 1'b1;
    bus.dealloc_PR_upper = upper_PR_t'(v);
    step();
    bus.dealloc_valid    = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(bus.alloc_valid), 32'd1);
    chk({tag, "_head"},  32'(bus.alloc_PR_upper), 32'd16);
    chk({tag, "_count"}, 32'(bus.count), 32'd16);
    chk({tag, "_dready"}, 32'(bus.dealloc_ready), 32'd1);
    chk({tag, "_below"}, 32'(bus.below_lower), 32'd0);
    chk({tag, "_above"}, 32'(bus.above_upper), 32'd0);
  endtask

  initial begin
    nrst = 1'b0;
    idle();
    step();
    step();
    chk_reset_state("rst_during");
    nrst = 1'b1;
    chk_reset_state("rst");

    // 1: drain the 16 initial entries
    for (int i = 0; i < 16; i++) begin
      chk("drain_init_pr", 32'(bus.alloc_PR_upper), 32'(16 + i));
      bus.alloc_ready = 1'b1;
      step();
    end
    bus.alloc_ready = 1'b0;
    chk("empty_valid", 32'(bus.alloc_valid), 32'd0);
    chk("empty_count", 32'(bus.count), 32'd0);
    chk("empty_below", 32'(bus.below_lower), 32'd1);
    bus.alloc_ready = 1'b1;
    step();
    bus.alloc_ready = 1'b0;
    chk("alloc_on_empty_count", 32'(bus.count), 32'd0);

    // 2: first write from empty appears next cycle
    dealloc(5);
    chk("deq5_valid", 32'(bus.alloc_valid), 32'd1);
    chk("deq5_pr", 32'(bus.alloc_PR_upper), 32'd5);
    chk("deq5_count", 32'(bus.count), 32'd1);
    chk("deq5_below", 32'(bus.below_lower), 32'd1);

    // 5: lower threshold 7 -> 8, upper threshold 24 -> 25
    for (int v = 6; v < 12; v++) dealloc(v);
    chk("c7_count", 32'(bus.count), 32'd7);
    chk("c7_below", 32'(bus.below_lower), 32'd1);
    dealloc(12);
    chk("c8_count", 32'(bus.count), 32'd8);
    chk("c8_below", 32'(bus.below_lower), 32'd0);
    for (int v = 13; v < 29; v++) dealloc(v);
    chk("c24_count", 32'(bus.count), 32'd24);
    chk("c24_above", 32'(bus.above_upper), 32'd0);
    dealloc(29);
    chk("c25_count", 32'(bus.count), 32'd25);
    chk("c25_above", 32'(bus.above_upper), 32'd1);
    chk("c25_head", 32'(bus.alloc_PR_upper), 32'd5);

    // 3: fill from 16 to full, then push against full
    do_reset();
    for (int v = 0; v < 16; v++) dealloc(v);
    chk("full_count", 32'(bus.count), 32'd32);
    chk("full_dready", 32'(bus.dealloc_ready), 32'd0);
    chk("full_above", 32'(bus.above_upper), 32'd1);
    bus.dealloc_valid    = 1'b1;
    bus.dealloc_PR_upper = upper_PR_t'(31);
    step();
    step();
    chk("full_ignore_count", 32'(bus.count), 32'd32);
    bus.alloc_ready = 1'b1;
    step();
    bus.alloc_ready   = 1'b0;
    bus.dealloc_valid = 1'b0;
    chk("full_both_count", 32'(bus.count), 32'd31);
    chk("full_both_head", 32'(bus.alloc_PR_upper), 32'd17);
    bus.alloc_ready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      chk("full_drain_pr", 32'(bus.alloc_PR_upper), (i < 15) ? 32'(17 + i) : 32'(i - 15));
      step();
    end
    chk("full_drain_valid", 32'(bus.alloc_valid), 32'd0);
    // empty: only the enqueue fires, no bypass
    bus.dealloc_valid    = 1'b1;
    bus.dealloc_PR_upper = upper_PR_t'(9);
    step();
    idle();
    chk("empty_both_count", 32'(bus.count), 32'd1);
    chk("empty_both_pr", 32'(bus.alloc_PR_upper), 32'd9);

    // 4: simultaneous traffic at 16, pointers wrap
    do_reset();
    bus.alloc_ready   = 1'b1;
    bus.dealloc_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.dealloc_PR_upper = upper_PR_t'((40 + k) % 32);
      chk("wrap_pr", 32'(bus.alloc_PR_upper), (k < 16) ? 32'(16 + k) : 32'((24 + k) % 32));
      chk("wrap_count", 32'(bus.count), 32'd16);
      step();
    end
    bus.dealloc_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      chk("wrap_tail_pr", 32'(bus.alloc_PR_upper), 32'(j));
      step();
    end
    bus.alloc_ready = 1'b0;
    chk("wrap_end_count", 32'(bus.count), 32'd0);

    // 6: reset in the middle of traffic at count 29
    do_reset();
    for (int v = 0; v < 13; v++) dealloc(v);
    chk("pre_rst_count", 32'(bus.count), 32'd29);
    chk("pre_rst_above", 32'(bus.above_upper), 32'd1);
    bus.alloc_ready      = 1'b1;
    bus.dealloc_valid    = 1'b1;
    bus.dealloc_PR_upper = upper_PR_t'(3);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    idle();
    chk_reset_state("mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
